// File: rtl/debounc_multi.sv
// -----------------------------------------------------------------------------
// debounc_multi
//   Multi-channel push-button debouncer. Each channel synchronises its raw
//   input through two flops, then only accepts a new level once the
//   synchronised input has disagreed with the current debounced level for
//   T_STABLE consecutive cycles. Single-cycle rise/fall pulses mark each
//   accepted edge.
//
//   Optional long-press detection is built only when the macro LONG_PRESS_EN
//   is defined; otherwise long_press is tied low and no hold logic exists.
//
// Parameters
//   N_CH      number of independent channels (1..32)
//   T_STABLE  cycles a level must hold before it is accepted
//   T_LONG    cycles dout must stay high before long_press pulses
//
// Ports
//   clk         clock, all logic on rising edge
//   rst         synchronous active-high reset
//   din         raw asynchronous button levels, bit i = channel i
//   dout        debounced level per channel
//   rise        one-cycle pulse when dout goes 0->1
//   fall        one-cycle pulse when dout goes 1->0
//   long_press  one-cycle pulse after dout has been high for T_LONG cycles
// -----------------------------------------------------------------------------
module debounc_multi #(
    parameter int unsigned N_CH     = 4,
    parameter logic [19:0] T_STABLE = 20'hF_4240,
    parameter logic [25:0] T_LONG   = 26'h2FA_F080
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] din,
    output logic [N_CH-1:0] dout,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] long_press
);

    if (N_CH < 1 || N_CH > 32 || T_STABLE == 20'd0 || T_LONG == 26'd0) begin : g_param_check
        $error("debounc_multi: parameter out of range");
    end

    logic [N_CH-1:0] r_s1;
    logic [N_CH-1:0] r_s2;
    logic [N_CH-1:0] r_dout;
    logic [N_CH-1:0] r_rise;
    logic [N_CH-1:0] r_fall;
    logic [19:0]     r_cnt [N_CH];

    logic [N_CH-1:0] w_mismatch;
    logic [N_CH-1:0] w_accept;

    // A channel accepts its new level on the cycle the counter already holds
    // T_STABLE-1 and the mismatch is still present.
    always_comb begin
        w_mismatch = r_s2 ^ r_dout;
        w_accept   = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            w_accept[i] = w_mismatch[i] && (r_cnt[i] == (T_STABLE - 20'd1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_dout <= '0;
            r_rise <= '0;
            r_fall <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1   <= din;
            r_s2   <= r_s1;
            r_dout <= r_dout ^ w_accept;
            r_rise <= w_accept & ~r_dout;
            r_fall <= w_accept & r_dout;
            // Any agreement wipes the count, so bounces never accumulate;
            // acceptance also clears it, so it never passes T_STABLE-1.
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (!w_mismatch[i] || w_accept[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 20'd1;
                end
            end
        end
    end

    assign dout = r_dout;
    assign rise = r_rise;
    assign fall = r_fall;

`ifdef LONG_PRESS_EN
    logic [25:0]     r_hold [N_CH];
    logic [N_CH-1:0] r_fired;
    logic [N_CH-1:0] r_long;

    // Hold count starts the cycle after the rise pulse, so the pulse lands
    // exactly T_LONG cycles after it; the fired flag then freezes the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fired <= '0;
            r_long  <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                r_hold[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                r_long[i] <= 1'b0;
                if (!r_dout[i]) begin
                    r_hold[i]  <= '0;
                    r_fired[i] <= 1'b0;
                end else if (!r_fired[i]) begin
                    if (r_hold[i] == (T_LONG - 26'd1)) begin
                        r_hold[i]  <= T_LONG;
                        r_fired[i] <= 1'b1;
                        r_long[i]  <= 1'b1;
                    end else begin
                        r_hold[i] <= r_hold[i] + 26'd1;
                    end
                end
            end
        end
    end

    assign long_press = r_long;
`else
    assign long_press = '0;
`endif

endmodule

// File: tb/tb_debounc_multi.sv
// -----------------------------------------------------------------------------
// tb_debounc_multi
//   Self-checking bench for debounc_multi. A behavioural model tracks, per
//   channel, how long the synchronised input has disagreed with the accepted
//   level and the edge number of the last accepted rise; every cycle the DUT
//   outputs are compared against it. Build with +define+LONG_PRESS_EN to
//   exercise the long-press path.
// -----------------------------------------------------------------------------
module tb_debounc_multi;

    localparam int unsigned N_CH     = 4;
    localparam logic [19:0] T_STABLE = 20'h00008;
    localparam logic [25:0] T_LONG   = 26'h000_000F;
    localparam int          TS       = int'(T_STABLE);
    localparam int          TL       = int'(T_LONG);
`ifdef LONG_PRESS_EN
    localparam bit LP = 1'b1;
`else
    localparam bit LP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N_CH-1:0] din = '0;
    logic [N_CH-1:0] dout;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] long_press;

    always #5 clk = ~clk;

    debounc_multi #(
        .N_CH     (N_CH),
        .T_STABLE (T_STABLE),
        .T_LONG   (T_LONG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .dout       (dout),
        .rise       (rise),
        .fall       (fall),
        .long_press (long_press)
    );

    // Reference model state
    int              m_edge;
    logic [N_CH-1:0] m_d1, m_d2;
    logic [N_CH-1:0] m_dout, m_rise, m_fall, m_long;
    int              m_run       [N_CH];
    int              m_rise_edge [N_CH];

    int n_vec = 0;
    int n_err = 0;

    // Advance one clock edge and update the model from the levels the DUT saw.
    task automatic step();
        logic [N_CH-1:0] seen;
        @(posedge clk);
        m_edge++;
        m_rise = '0;
        m_fall = '0;
        m_long = '0;
        if (rst) begin
            m_d1   = '0;
            m_d2   = '0;
            m_dout = '0;
            for (int i = 0; i < N_CH; i++) begin
                m_run[i]       = 0;
                m_rise_edge[i] = -1000000;
            end
        end else begin
            seen = m_d2;
            m_d2 = m_d1;
            m_d1 = din;
            for (int i = 0; i < N_CH; i++) begin
                if (LP && m_dout[i] && (m_edge - m_rise_edge[i] == TL))
                    m_long[i] = 1'b1;
                if (seen[i] != m_dout[i]) begin
                    m_run[i]++;
                    if (m_run[i] == TS) begin
                        m_run[i]  = 0;
                        m_dout[i] = ~m_dout[i];
                        if (m_dout[i]) begin
                            m_rise[i]      = 1'b1;
                            m_rise_edge[i] = m_edge;
                        end else begin
                            m_fall[i] = 1'b1;
                        end
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            din = N_CH'($urandom);
            step();
            n_vec++;
            if ({dout, rise, fall, long_press} !== '0) begin
                n_err++;
                $display("FAIL reset cyc%0d: dout/rise/fall/long got %b/%b/%b/%b want all 0",
                         c, dout, rise, fall, long_press);
            end
        end
        rst = 1'b0;
        din = '0;
    endtask

    task automatic test_bounce();
        int pat [7] = '{1, 1, 0, 1, 1, 1, 0};
        apply_reset();
        for (int c = 0; c < 22; c++) begin
            din[0] = (c < 7) ? pat[c][0] : 1'b0;
            step();
            n_vec++;
            if ({dout, rise, fall, long_press} !== {m_dout, m_rise, m_fall, m_long}) begin
                n_err++;
                $display("FAIL bounce cyc%0d: got %b/%b/%b/%b want %b/%b/%b/%b", c,
                         dout, rise, fall, long_press, m_dout, m_rise, m_fall, m_long);
            end
            n_vec++;
            if ({dout[0], rise[0], fall[0]} !== 3'b000) begin
                n_err++;
                $display("FAIL bounce_ch0 cyc%0d: dout/rise/fall got %b%b%b want 000",
                         c, dout[0], rise[0], fall[0]);
            end
        end
    endtask

    task automatic test_clean_press();
        int samp_edge = -1;
        int rise_edge = -1;
        int n_rise    = 0;
        apply_reset();
        for (int c = 0; c < 20; c++) begin
            din[0] = 1'b1;
            step();
            if (c == 0) samp_edge = m_edge;
            if (rise[0]) begin
                n_rise++;
                rise_edge = m_edge;
            end
            n_vec++;
            if ({dout, rise, fall, long_press} !== {m_dout, m_rise, m_fall, m_long}) begin
                n_err++;
                $display("FAIL press cyc%0d: got %b/%b/%b/%b want %b/%b/%b/%b", c,
                         dout, rise, fall, long_press, m_dout, m_rise, m_fall, m_long);
            end
        end
        // The edge that samples the new level counts as edge 1.
        n_vec++;
        if (rise_edge - samp_edge + 1 != TS + 2) begin
            n_err++;
            $display("FAIL press_latency: got %0d edges want %0d", rise_edge - samp_edge + 1, TS + 2);
        end
        n_vec++;
        if (n_rise != 1) begin
            n_err++;
            $display("FAIL press_rise_count: got %0d want 1", n_rise);
        end
    endtask

    task automatic test_release();
        int samp_edge = -1;
        int fall_edge = -1;
        int n_fall    = 0;
        apply_reset();
        // 12 high, short low glitch (3), high 4, then final release low 20
        for (int c = 0; c < 39; c++) begin
            din[0] = (c < 12) ? 1'b1 : (c < 15) ? 1'b0 : (c < 19) ? 1'b1 : 1'b0;
            step();
            if (c == 19) samp_edge = m_edge;
            if (fall[0]) begin
                n_fall++;
                fall_edge = m_edge;
            end
            n_vec++;
            if ({dout, rise, fall, long_press} !== {m_dout, m_rise, m_fall, m_long}) begin
                n_err++;
                $display("FAIL release cyc%0d: got %b/%b/%b/%b want %b/%b/%b/%b", c,
                         dout, rise, fall, long_press, m_dout, m_rise, m_fall, m_long);
            end
        end
        n_vec++;
        if (n_fall != 1) begin
            n_err++;
            $display("FAIL release_fall_count: got %0d want 1", n_fall);
        end
        n_vec++;
        if (fall_edge - samp_edge + 1 != TS + 2) begin
            n_err++;
            $display("FAIL release_latency: got %0d edges want %0d", fall_edge - samp_edge + 1, TS + 2);
        end
        din = '0;
    endtask

    task automatic test_long_hold();
        int n_long    = 0;
        int rise_edge = -1;
        int long_edge = -1;
        apply_reset();
        for (int c = 0; c < 55; c++) begin
            din[1] = (c < 40);
            step();
            if (rise[1]) rise_edge = m_edge;
            if (long_press[1]) begin
                n_long++;
                long_edge = m_edge;
            end
            n_vec++;
            if ({dout, rise, fall, long_press} !== {m_dout, m_rise, m_fall, m_long}) begin
                n_err++;
                $display("FAIL long cyc%0d: got %b/%b/%b/%b want %b/%b/%b/%b", c,
                         dout, rise, fall, long_press, m_dout, m_rise, m_fall, m_long);
            end
        end
        n_vec++;
        if (n_long != (LP ? 1 : 0)) begin
            n_err++;
            $display("FAIL long_count: got %0d want %0d", n_long, LP ? 1 : 0);
        end
        if (LP) begin
            n_vec++;
            if (long_edge - rise_edge != TL) begin
                n_err++;
                $display("FAIL long_offset: got %0d want %0d", long_edge - rise_edge, TL);
            end
        end
        din = '0;
    endtask

    task automatic test_multi();
        int n_rise_cyc = 0;
        apply_reset();
        for (int c = 0; c < 14; c++) begin
            din = '1;
            step();
            if (rise != '0) begin
                n_rise_cyc++;
                n_vec++;
                if (rise !== 4'b1111) begin
                    n_err++;
                    $display("FAIL multi_rise_aligned: got %b want 1111", rise);
                end
            end
            n_vec++;
            if ({dout, rise, fall, long_press} !== {m_dout, m_rise, m_fall, m_long}) begin
                n_err++;
                $display("FAIL multi cyc%0d: got %b/%b/%b/%b want %b/%b/%b/%b", c,
                         dout, rise, fall, long_press, m_dout, m_rise, m_fall, m_long);
            end
        end
        n_vec++;
        if (n_rise_cyc != 1) begin
            n_err++;
            $display("FAIL multi_rise_cycles: got %0d want 1", n_rise_cyc);
        end
        din = '0;
    endtask

    task automatic test_reset_mid();
        int samp_edge = -1;
        int rise_edge = -1;
        apply_reset();
        din[2] = 1'b1;
        repeat (7) step();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_vec++;
            if ({dout, rise, fall, long_press} !== '0) begin
                n_err++;
                $display("FAIL reset_mid cyc%0d: got %b/%b/%b/%b want all 0",
                         c, dout, rise, fall, long_press);
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (c == 0) samp_edge = m_edge;
            if (rise[2]) rise_edge = m_edge;
            n_vec++;
            if ({dout, rise, fall, long_press} !== {m_dout, m_rise, m_fall, m_long}) begin
                n_err++;
                $display("FAIL reset_mid_after cyc%0d: got %b/%b/%b/%b want %b/%b/%b/%b", c,
                         dout, rise, fall, long_press, m_dout, m_rise, m_fall, m_long);
            end
        end
        n_vec++;
        if (rise_edge - samp_edge + 1 != TS + 2) begin
            n_err++;
            $display("FAIL reset_mid_latency: got %0d edges want %0d", rise_edge - samp_edge + 1, TS + 2);
        end
        din = '0;
    endtask

    task automatic test_random();
        int hold [N_CH];
        apply_reset();
        for (int i = 0; i < N_CH; i++) hold[i] = 0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N_CH; i++) begin
                if (hold[i] == 0) begin
                    din[i]  = ~din[i];
                    hold[i] = (($urandom & 3) == 0) ? $urandom_range(40, 15) : $urandom_range(12, 1);
                end
                hold[i]--;
            end
            rst = (($urandom & 127) == 0);
            step();
            n_vec++;
            if ({dout, rise, fall, long_press} !== {m_dout, m_rise, m_fall, m_long}) begin
                n_err++;
                $display("FAIL random cyc%0d: got %b/%b/%b/%b want %b/%b/%b/%b", c,
                         dout, rise, fall, long_press, m_dout, m_rise, m_fall, m_long);
            end
            n_vec++;
            if ((rise & fall) !== '0) begin
                n_err++;
                $display("FAIL random_rise_fall_overlap cyc%0d: got %b want 0000", c, rise & fall);
            end
        end
        rst = 1'b0;
        din = '0;
    endtask

    initial begin
        m_edge = 0;
        m_d1   = '0;
        m_d2   = '0;
        m_dout = '0;
        m_rise = '0;
        m_fall = '0;
        m_long = '0;
        for (int i = 0; i < N_CH; i++) begin
            m_run[i]       = 0;
            m_rise_edge[i] = -1000000;
        end
        #2;
        test_reset();
        test_bounce();
        test_clean_press();
        test_release();
        test_long_hold();
        test_multi();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/debounc_multi.md
DEBOUNC_MULTI -- requirements
Module: debounc_multi

Interface
REQ-001 Parameter N_CH, default 4: number of independent button channels, range 1..32.
REQ-002 Parameter T_STABLE, 20 bits, default 20'hF_4240: cycles an input must hold a level before it is accepted, range 1..2^20-1.
REQ-003 Parameter T_LONG, 26 bits, default 26'h2FA_F080: cycles `dout` must stay high before a long press is reported, range 1..2^26-1.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 din  input  N_CH  raw asynchronous button levels; bit i belongs to channel i.
REQ-007 dout  output  N_CH  debounced level per channel.
REQ-008 rise  output  N_CH  one-cycle pulse per channel when `dout` goes 0->1.
REQ-009 fall  output  N_CH  one-cycle pulse per channel when `dout` goes 1->0.
REQ-010 long_press  output  N_CH  one-cycle pulse per channel after the long-hold time (see Configuration).

Function
REQ-011 Each channel SHALL pass din[i] through a 2-flop synchroniser (s1, s2) before any other use.
REQ-012 Each channel SHALL have a 20-bit stable counter: increment when s2 != dout[i]; clear when s2 == dout[i].
REQ-013 When the counter equals T_STABLE-1 and a mismatch is still present:
- dout[i] SHALL toggle on that edge;
- the counter SHALL clear on the same edge.
REQ-014 Latency: dout[i] SHALL change on the (T_STABLE+2)th rising edge after the first edge that samples the new din level, provided din holds that level throughout.
REQ-015 Any return of s2 to the current dout[i] level before acceptance SHALL clear the counter; partial counts SHALL never accumulate across bounces.
REQ-016 rise[i] / fall[i] SHALL be high for exactly the one cycle in which dout[i] carries the new value; they SHALL never be high together.
REQ-017 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each follow REQ-013..016 with no interaction.
REQ-018 The counter SHALL never exceed T_STABLE-1 and SHALL never wrap.

Reset
REQ-019 While rst=1 at a rising edge, the following SHALL all be 0 on the next cycle: s1, s2, every counter, dout, rise, fall, long_press and the long-press state.
REQ-020 Reset asserted mid-count or mid-hold SHALL discard all progress; after rst deasserts, a held-high din SHALL need the full REQ-014 latency again.
REQ-021 An input that is high at reset release SHALL produce a rise pulse once it is accepted.

Configuration
REQ-022 Macro LONG_PRESS_EN SHALL control the long-press feature.
REQ-023 With LONG_PRESS_EN defined, each channel SHALL carry a 26-bit hold counter and a fired flag:
- the counter clears while dout[i]=0 and increments each cycle while dout[i]=1;
- long_press[i] pulses one cycle when the count reaches T_LONG, i.e. T_LONG cycles after the rise pulse;
- the counter then saturates and the fired flag suppresses further pulses until dout[i] falls.
REQ-024 Without LONG_PRESS_EN, the following SHALL be absent: the hold counters, the fired flags and all long-press logic.
REQ-025 Without LONG_PRESS_EN, the long_press port SHALL remain and be tied to all zeros.
REQ-026 The port list SHALL be identical in both builds.

Verification
Bench settings: N_CH=4, T_STABLE=20'h00008, T_LONG=26'h000_000F, clock period 10 ns; rst held high 3 cycles before each scenario.
REQ-027 Bounce: din[0] toggles high 2 / low 1 / high 3 / low 1 cycles, then stays low -> dout[0], rise[0] and fall[0] stay 0 throughout.
REQ-028 Clean press: din[0] 0->1 and held 20 cycles -> dout[0] rises on the 10th edge after the edge that samples din high; rise[0] high that cycle only.
REQ-029 Release: din[0] then falls and is held low -> dout[0] falls 10 edges later with a single fall[0] pulse; any bounce shorter than 8 cycles before the release is ignored.
REQ-030 Long hold, LONG_PRESS_EN defined: din[1] held high 40 cycles -> long_press[1] pulses once, 15 cycles after rise[1], and never again during the hold. Same stimulus without the macro -> long_press stays 0.
REQ-031 Multi-channel and reset: din[3:0]=4'b1111 at once -> all four rise pulses land on the same cycle. Separately, rst asserted 5 cycles into a count on din[2] -> all outputs 0, and after release acceptance takes the full 10 edges again.
